// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types, opcode constants and opcode classifiers for the ALU sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    // Opcodes are compared on their low seven bits; wider opcodes must have zero upper bits.
    localparam int OP_LO_W = 7;

    localparam logic [OP_LO_W-1:0] OP_NOP = 7'd0;
    localparam logic [OP_LO_W-1:0] OP_ADD = 7'd1;
    localparam logic [OP_LO_W-1:0] OP_BEQ = 7'd39;
    localparam logic [OP_LO_W-1:0] OP_BNE = 7'd40;
    localparam logic [OP_LO_W-1:0] OP_BLT = 7'd41;
    localparam logic [OP_LO_W-1:0] OP_BRA = 7'd64;
    localparam logic [OP_LO_W-1:0] OP_BSR = 7'd65;

    localparam int CCR_C    = 0;
    localparam int CCR_V    = 1;
    localparam int CCR_Z    = 2;
    localparam int CCR_N    = 3;
    localparam int CCR_INR  = 4;
    localparam int CCR_IFNR = 5;
    localparam int CCR_NOP  = 6;
    localparam int CCR_W    = 7;

    // Opcodes that leave the arithmetic flags untouched and raise the NOP bit.
    function automatic logic is_nop(input logic [OP_LO_W-1:0] op);
        return (op == OP_NOP) || (op == 7'd16) || (op == 7'd17) || (op == 7'd18) ||
               (op == OP_BRA) || (op == OP_BSR);
    endfunction

    // Every opcode the ALU implements; anything else is reported through INR.
    function automatic logic is_recognised(input logic [OP_LO_W-1:0] op);
        return is_nop(op) ||
               ((op >= OP_ADD) && (op <= 7'd15)) ||
               ((op >= 7'd32) && (op <= 7'd45));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request round-robin arbiter, pointer advances past the granted port
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    // ptr_q names the port that wins when both request; 0 after reset.
    logic ptr_q;

    assign gnt_id_o = (req_i == 2'b11) ? ptr_q : req_i[1];
    assign gnt_o    = req_i & (gnt_id_o ? 2'b10 : 2'b01);

    // Hand priority to the other port whenever a grant is actually taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else if (advance_i && (req_i != 2'b00)) begin
            ptr_q <= ~gnt_id_o;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - shares one ALU between two requesters, owns the CCR and resolves branches
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int W      = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [W-1:0] req0_op_i,
    input  logic [W-1:0] req0_a_i,
    input  logic [W-1:0] req0_b_i,

    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [W-1:0] req1_op_i,
    input  logic [W-1:0] req1_a_i,
    input  logic [W-1:0] req1_b_i,

    output logic [W-1:0] alu_op_o,
    output logic [W-1:0] alu_ra_o,
    output logic [W-1:0] alu_rb_o,
    output logic         alu_nop_o,
    input  logic [W-1:0] alu_rz_i,
    input  logic [3:0]   alu_flags_i,

    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [W-1:0] rsp_result_o,
    output logic         rsp_taken_o,

    output logic [W-1:0] ccr_out_o
);

    localparam logic [1:0] CNT_LAST = 2'(SETTLE - 1);

    state_e              state_q;
    logic [1:0]          cnt_q;
    logic                id_q;
    logic [W-1:0]        alu_op_q;
    logic [W-1:0]        alu_ra_q;
    logic [W-1:0]        alu_rb_q;
    logic                alu_nop_q;
    logic [CCR_W-1:0]    ccr_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [W-1:0]        rsp_result_q;
    logic                rsp_taken_q;

    logic [1:0]          gnt;
    logic                gnt_id;
    logic                in_idle;
    logic                handshake;
    logic [W-1:0]        sel_op;
    logic [W-1:0]        sel_a;
    logic [W-1:0]        sel_b;
    logic                sel_nop;
    logic                cur_hi_zero;
    logic                cur_nop;
    logic                cur_rec;
    logic [OP_LO_W-1:0]  cur_lo;
    logic [CCR_W-1:0]    ccr_d;
    logic [W-1:0]        result_d;
    logic                taken_d;

    rr_arbiter2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     ({req1_valid_i, req0_valid_i}),
        .advance_i (handshake),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id)
    );

    // Ready only ever goes to a port that is both granted and valid, and only while idle.
    assign in_idle      = (state_q == S_IDLE);
    assign req0_ready_o = in_idle & gnt[0];
    assign req1_ready_o = in_idle & gnt[1];
    assign handshake    = req0_ready_o | req1_ready_o;

    assign sel_op  = gnt_id ? req1_op_i : req0_op_i;
    assign sel_a   = gnt_id ? req1_a_i  : req0_a_i;
    assign sel_b   = gnt_id ? req1_b_i  : req0_b_i;
    assign sel_nop = (sel_op[W-1:OP_LO_W] == '0) && is_nop(sel_op[OP_LO_W-1:0]);

    // Classification of the opcode currently held on the ALU.
    assign cur_hi_zero = (alu_op_q[W-1:OP_LO_W] == '0);
    assign cur_lo      = alu_op_q[OP_LO_W-1:0];
    assign cur_nop     = cur_hi_zero && is_nop(cur_lo);
    assign cur_rec     = cur_hi_zero && is_recognised(cur_lo);

    // Next CCR, response result and branch outcome from the settled ALU outputs.
    always_comb begin
        ccr_d           = ccr_q;
        result_d        = alu_rz_i;
        taken_d         = 1'b0;
        ccr_d[CCR_IFNR] = 1'b0;
        if (cur_nop) begin
            ccr_d[CCR_NOP] = 1'b1;
            ccr_d[CCR_INR] = 1'b0;
        end else if (cur_rec) begin
            ccr_d[CCR_N]   = alu_flags_i[3];
            ccr_d[CCR_Z]   = alu_flags_i[2];
            ccr_d[CCR_V]   = alu_flags_i[1];
            ccr_d[CCR_C]   = alu_flags_i[0];
            ccr_d[CCR_NOP] = 1'b0;
            ccr_d[CCR_INR] = 1'b0;
        end else begin
            ccr_d[CCR_NOP] = 1'b0;
            ccr_d[CCR_INR] = 1'b1;
            result_d       = '0;
        end
        if (cur_hi_zero) begin
            case (cur_lo)
                OP_BEQ:         taken_d = ccr_d[CCR_Z];
                OP_BNE:         taken_d = ~ccr_d[CCR_Z];
                OP_BLT:         taken_d = ccr_d[CCR_N];
                OP_BRA, OP_BSR: taken_d = 1'b1;
                default:        taken_d = 1'b0;
            endcase
        end
    end

    // Sequencer: accept one op, hold it on the ALU for SETTLE cycles, then present the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            alu_op_q     <= '0;
            alu_ra_q     <= '0;
            alu_rb_q     <= '0;
            alu_nop_q    <= 1'b0;
            ccr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_taken_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        alu_op_q  <= sel_op;
                        alu_ra_q  <= sel_a;
                        alu_rb_q  <= sel_b;
                        alu_nop_q <= sel_nop;
                        id_q      <= gnt_id;
                        cnt_q     <= '0;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cnt_q == CNT_LAST) begin
                        ccr_q        <= ccr_d;
                        rsp_result_q <= result_d;
                        rsp_taken_q  <= taken_d;
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_op_o     = alu_op_q;
    assign alu_ra_o     = alu_ra_q;
    assign alu_rb_o     = alu_rb_q;
    assign alu_nop_o    = alu_nop_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_taken_o  = rsp_taken_q;
    assign ccr_out_o    = {{(W-CCR_W){1'b0}}, ccr_q};

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a behavioural model
module tb_alu_op_sequencer;

    localparam int SETTLE = 1;
    localparam int W      = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_op = '0, req0_a = '0, req0_b = '0;
    logic [W-1:0] req1_op = '0, req1_a = '0, req1_b = '0;
    logic [W-1:0] alu_op, alu_ra, alu_rb, alu_rz;
    logic         alu_nop;
    logic [3:0]   alu_flags;
    logic         rsp_valid, rsp_id, rsp_taken;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result, ccr_out;

    int errors = 0;
    int checks = 0;

    logic [6:0]   ccr_m = '0;
    logic [W-1:0] last_res;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SETTLE(SETTLE), .W(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .alu_op_o     (alu_op),
        .alu_ra_o     (alu_ra),
        .alu_rb_o     (alu_rb),
        .alu_nop_o    (alu_nop),
        .alu_rz_i     (alu_rz),
        .alu_flags_i  (alu_flags),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_taken_o  (rsp_taken),
        .ccr_out_o    (ccr_out)
    );

    // External ALU stand-in: returns {N,Z,V,C, RZ}.
    function automatic logic [35:0] alu_model(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic v, c;
        v = 1'b0;
        c = 1'b0;
        if (op == 32'd1) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (op == 32'd2 || (op >= 32'd39 && op <= 32'd41)) begin
            s = {1'b0, a} - {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            r = a ^ b;
        end
        return {r[31], (r == 32'd0), v, c, r};
    endfunction

    always_comb {alu_flags, alu_rz} = alu_model(alu_op, alu_ra, alu_rb);

    function automatic bit m_is_nop(input logic [31:0] op);
        return op == 0 || op == 16 || op == 17 || op == 18 || op == 64 || op == 65;
    endfunction

    function automatic bit m_is_rec(input logic [31:0] op);
        return m_is_nop(op) || (op >= 1 && op <= 15) || (op >= 32 && op <= 45);
    endfunction

    // Architectural effect of one op on the CCR, plus the response it should produce.
    task automatic model_op(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic tk);
        logic [35:0] fr;
        fr = alu_model(op, a, b);
        if (m_is_nop(op)) begin
            ccr_m = {3'b100, ccr_m[3:0]};
            res   = fr[31:0];
        end else if (m_is_rec(op)) begin
            ccr_m = {3'b000, fr[35:32]};
            res   = fr[31:0];
        end else begin
            ccr_m = {3'b001, ccr_m[3:0]};
            res   = '0;
        end
        case (op)
            32'd39:         tk = ccr_m[2];
            32'd40:         tk = ~ccr_m[2];
            32'd41:         tk = ccr_m[3];
            32'd64, 32'd65: tk = 1'b1;
            default:        tk = 1'b0;
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int port, input logic [31:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
        if (port == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = v;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = v;
        end
    endtask

    // Called just after a negedge with the DUT idle; returns at the negedge where the response is visible.
    task automatic issue_op(input int port, input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        et;
        int          n;
        model_op(op, a, b, er, et);
        last_res = er;
        drive(port, op, a, b, 1'b1);
        #1;
        n = 0;
        while (!(port == 0 ? req0_ready : req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("grant_ready", port == 0 ? req0_ready : req1_ready, 1);
        @(posedge clk); #1;
        drive(port, op, a, b, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk); n++;
        end
        check("latency", n, SETTLE + 1);
        check("rsp_id", rsp_id, port);
        check("rsp_result", rsp_result, er);
        check("rsp_taken", rsp_taken, et);
        check("ccr_out", ccr_out, {25'b0, ccr_m});
        check("ready_in_resp", {req1_ready, req0_ready}, 0);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_drop", rsp_valid, 0);
        rsp_ready = 1'b0;
    endtask

    logic [31:0] r_op, r_a, r_b, er2;
    logic        et2;
    int          port_r, hold_r, n;
    bit          seen;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_alu_op", alu_op, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ccr", ccr_out, 0);
        @(negedge clk);

        // Basic ADD, branches, flag preservation across unrecognised and NOP ops.
        issue_op(0, 32'd1, 32'd5, 32'd7);          release_rsp();
        issue_op(1, 32'd39, 32'd9, 32'd9);         release_rsp();
        issue_op(1, 32'd40, 32'd9, 32'd9);         release_rsp();
        issue_op(0, 32'd41, 32'd2, 32'd5);         release_rsp();
        issue_op(0, 32'd1, 32'hFFFF_FFFF, 32'd1);  release_rsp();
        issue_op(1, 32'd50, 32'd3, 32'd4);         release_rsp();
        issue_op(0, 32'd0, 32'd3, 32'd4);
        check("alu_nop_flag", alu_nop, 1);
        release_rsp();

        // Back-pressure: response must hold while a new request waits.
        issue_op(0, 32'd1, 32'd10, 32'd20);
        drive(1, 32'd2, 32'd8, 32'd3, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, last_res);
            check("hold_ready", {req1_ready, req0_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("release_drop", rsp_valid, 0);
        check("release_idle_ready", req1_ready, 1);
        issue_op(1, 32'd2, 32'd8, 32'd3);          release_rsp();

        // Randomised single-port traffic.
        for (int i = 0; i < 30; i++) begin
            port_r = $urandom_range(0, 1);
            r_op   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70));
            r_a    = $urandom;
            r_b    = ($urandom_range(0, 2) == 0) ? r_a : $urandom;
            issue_op(port_r, r_op, r_a, r_b);
            hold_r = $urandom_range(0, 2);
            repeat (hold_r) begin
                @(negedge clk);
                check("rand_hold", rsp_result, last_res);
            end
            release_rsp();
        end

        // Reset while the op is settling on the ALU.
        drive(0, 32'd1, 32'd4, 32'd4, 1'b1);
        #1;
        check("pre_rst_ready", req0_ready, 1);
        @(posedge clk); #1;
        drive(0, 32'd1, 32'd4, 32'd4, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ccr_m = '0;
        check("mid_rst_alu", {alu_op, alu_ra, alu_rb} == '0, 1);
        check("mid_rst_nop", alu_nop, 0);
        check("mid_rst_rsp", {rsp_valid, rsp_id, rsp_taken}, 0);
        check("mid_rst_result", rsp_result, 0);
        check("mid_rst_ccr", ccr_out, 0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_rst", seen, 0);

        // Contention: both ports always valid, grants must alternate starting at port 0.
        drive(0, 32'd2, 32'd3, 32'd3, 1'b1);
        drive(1, 32'd1, 32'd1, 32'd1, 1'b1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            do begin
                @(negedge clk); n++;
            end while (!rsp_valid && n < 20);
            if (i % 2 == 0) model_op(32'd2, 32'd3, 32'd3, er2, et2);
            else            model_op(32'd1, 32'd1, 32'd1, er2, et2);
            check("rr_valid", rsp_valid, 1);
            check("rr_id", rsp_id, i % 2);
            check("rr_result", rsp_result, er2);
            check("rr_ccr", ccr_out, {25'b0, ccr_m});
        end
        drive(0, 32'd2, 32'd3, 32'd3, 1'b0);
        drive(1, 32'd1, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rr_end_drop", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
